// File: rtl/wb_stage.sv
// wb_stage: write-back pipeline stage.
// Registers the instruction arriving from the memory stage and turns it into
// a register-file write (enable, index, data).
// Optional feature: define WB_RETIRE_CNT_EN to build the retired-instruction
// counter; otherwise retired_cnt is tied to zero.

`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif

`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module wb_stage #(
    parameter int REG_ADDR_LEN   = 4,
    parameter int RETIRE_CNT_LEN = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic [`ADDRESS_LEN-1:0]   pc_in,
    input  logic                      WB_EN_in,
    input  logic                      MEM_R_EN_in,
    input  logic [REG_ADDR_LEN-1:0]   Dest_in,
    input  logic [`WORD_LEN-1:0]      ALU_Res_in,
    input  logic [`WORD_LEN-1:0]      Mem_Data_in,
    output logic [`ADDRESS_LEN-1:0]   pc,
    output logic                      WB_EN,
    output logic [REG_ADDR_LEN-1:0]   Dest,
    output logic [`WORD_LEN-1:0]      WB_Value,
    output logic                      wb_valid,
    output logic [RETIRE_CNT_LEN-1:0] retired_cnt
);

    logic                    valid_q;
    logic                    wb_en_q;
    logic                    mem_r_en_q;
    logic [REG_ADDR_LEN-1:0] dest_q;
    logic [`ADDRESS_LEN-1:0] pc_q;
    logic [`WORD_LEN-1:0]    alu_res_q;
    logic [`WORD_LEN-1:0]    mem_data_q;

    // Stage register: reset and flush both load an all-zero bubble, freeze holds.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            valid_q    <= 1'b0;
            wb_en_q    <= 1'b0;
            mem_r_en_q <= 1'b0;
            dest_q     <= '0;
            pc_q       <= '0;
            alu_res_q  <= '0;
            mem_data_q <= '0;
        end else if (!freeze) begin
            valid_q    <= valid_in;
            wb_en_q    <= WB_EN_in;
            mem_r_en_q <= MEM_R_EN_in;
            dest_q     <= Dest_in;
            pc_q       <= pc_in;
            alu_res_q  <= ALU_Res_in;
            mem_data_q <= Mem_Data_in;
        end
    end

    // Write-back outputs: a bubble never writes, loads return memory data.
    // A frozen stage keeps WB_EN high, which just repeats the same write.
    always_comb begin
        WB_EN    = wb_en_q & valid_q;
        WB_Value = mem_r_en_q ? mem_data_q : alu_res_q;
        pc       = pc_q;
        Dest     = dest_q;
        wb_valid = valid_q;
    end

`ifdef WB_RETIRE_CNT_EN
    localparam logic [RETIRE_CNT_LEN-1:0] CNT_ONE = RETIRE_CNT_LEN'(1);

    logic [RETIRE_CNT_LEN-1:0] retire_cnt_q;

    // Count each real instruction as it leaves the stage; a flush replaces
    // what comes in, not what goes out, so it does not suppress the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (valid_q && !freeze) begin
            retire_cnt_q <= retire_cnt_q + CNT_ONE;
        end
    end

    assign retired_cnt = retire_cnt_q;
`else
    assign retired_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
// Covers reset, load/ALU write-back, freeze hold, flush-over-freeze,
// bubble write suppression, reset priority and the retire counter
// (counter checks follow WB_RETIRE_CNT_EN).

`ifndef ADDRESS_LEN
`define ADDRESS_LEN 32
`endif

`ifndef WORD_LEN
`define WORD_LEN 32
`endif

module tb_wb_stage;

    localparam int REG_ADDR_LEN   = 4;
    localparam int RETIRE_CNT_LEN = 32;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      freeze;
    logic                      flush;
    logic                      valid_in;
    logic [`ADDRESS_LEN-1:0]   pc_in;
    logic                      WB_EN_in;
    logic                      MEM_R_EN_in;
    logic [REG_ADDR_LEN-1:0]   Dest_in;
    logic [`WORD_LEN-1:0]      ALU_Res_in;
    logic [`WORD_LEN-1:0]      Mem_Data_in;
    logic [`ADDRESS_LEN-1:0]   pc;
    logic                      WB_EN;
    logic [REG_ADDR_LEN-1:0]   Dest;
    logic [`WORD_LEN-1:0]      WB_Value;
    logic                      wb_valid;
    logic [RETIRE_CNT_LEN-1:0] retired_cnt;

    int n_checks = 0;
    int n_fails  = 0;

    wb_stage #(
        .REG_ADDR_LEN  (REG_ADDR_LEN),
        .RETIRE_CNT_LEN(RETIRE_CNT_LEN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .freeze     (freeze),
        .flush      (flush),
        .valid_in   (valid_in),
        .pc_in      (pc_in),
        .WB_EN_in   (WB_EN_in),
        .MEM_R_EN_in(MEM_R_EN_in),
        .Dest_in    (Dest_in),
        .ALU_Res_in (ALU_Res_in),
        .Mem_Data_in(Mem_Data_in),
        .pc         (pc),
        .WB_EN      (WB_EN),
        .Dest       (Dest),
        .WB_Value   (WB_Value),
        .wb_valid   (wb_valid),
        .retired_cnt(retired_cnt)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Expected retire count after n real instructions have left the stage.
    function automatic logic [RETIRE_CNT_LEN-1:0] cnt_exp(input int n);
`ifdef WB_RETIRE_CNT_EN
        return RETIRE_CNT_LEN'(n);
`else
        return '0;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input logic v, input logic wb, input logic mr,
                                  input logic [REG_ADDR_LEN-1:0] d,
                                  input logic [`WORD_LEN-1:0] alu,
                                  input logic [`WORD_LEN-1:0] mem,
                                  input logic [`ADDRESS_LEN-1:0] p);
        valid_in    = v;
        WB_EN_in    = wb;
        MEM_R_EN_in = mr;
        Dest_in     = d;
        ALU_Res_in  = alu;
        Mem_Data_in = mem;
        pc_in       = p;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs,
                                input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [`ADDRESS_LEN-1:0] e_pc,
                             input logic e_wb_en, input logic [REG_ADDR_LEN-1:0] e_dest,
                             input logic [`WORD_LEN-1:0] e_val, input logic e_valid);
        check_output({tag, ".pc"},       pc,       e_pc);
        check_output({tag, ".WB_EN"},    WB_EN,    e_wb_en);
        check_output({tag, ".Dest"},     Dest,     e_dest);
        check_output({tag, ".WB_Value"}, WB_Value, e_val);
        check_output({tag, ".wb_valid"}, wb_valid, e_valid);
    endtask

    // Directed sequence
    initial begin
        rst    = 1'b1;
        freeze = 1'b0;
        flush  = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b1, 4'd9, 32'h1111_2222, 32'h3333_4444, 32'h0000_0ABC);

        // Reset with nonzero inputs clears everything
        tick();
        check_all("reset", '0, 1'b0, '0, '0, 1'b0);
        check_output("reset.retired_cnt", retired_cnt, '0);

        // Load instruction: write data comes from memory
        rst = 1'b0;
        apply_stimulus(1'b1, 1'b1, 1'b1, 4'd3, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0100);
        tick();
        check_all("load", 32'h100, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b1);

        // Same but ALU result selected; load retires on this edge
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd3, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0000_0104);
        tick();
        check_all("alu", 32'h104, 1'b1, 4'd3, 32'h0000_0040, 1'b1);
        check_output("alu.retired_cnt", retired_cnt, cnt_exp(1));

        // Latch Dest=5, then freeze three cycles with new inputs
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd5, 32'h0000_0055, 32'h0000_0000, 32'h0000_0108);
        tick();
        check_all("dest5", 32'h108, 1'b1, 4'd5, 32'h0000_0055, 1'b1);
        freeze = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd7, 32'h0000_0077, 32'h0000_0000, 32'h0000_010C);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all($sformatf("freeze%0d", i), 32'h108, 1'b1, 4'd5, 32'h0000_0055, 1'b1);
        end
        check_output("freeze.retired_cnt", retired_cnt, cnt_exp(2));
        freeze = 1'b0;
        tick();
        check_all("unfreeze", 32'h10C, 1'b1, 4'd7, 32'h0000_0077, 1'b1);
        check_output("unfreeze.retired_cnt", retired_cnt, cnt_exp(3));

        // Flush beats freeze: bubble loaded
        flush  = 1'b1;
        freeze = 1'b1;
        apply_stimulus(1'b1, 1'b1, 1'b1, 4'd6, 32'h0000_0066, 32'h0000_6666, 32'h0000_0110);
        tick();
        check_all("flush", '0, 1'b0, '0, '0, 1'b0);
        flush  = 1'b0;
        freeze = 1'b0;

        // Write request on an invalid instruction must not write
        apply_stimulus(1'b0, 1'b1, 1'b0, 4'd2, 32'h0000_0022, 32'h0000_0000, 32'h0000_0114);
        tick();
        check_all("bubble", 32'h114, 1'b0, 4'd2, 32'h0000_0022, 1'b0);

        // Reset beats freeze and flush
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd4, 32'h0000_0044, 32'h0000_0000, 32'h0000_0118);
        tick();
        check_all("pre_rst", 32'h118, 1'b1, 4'd4, 32'h0000_0044, 1'b1);
        rst    = 1'b1;
        freeze = 1'b1;
        flush  = 1'b1;
        tick();
        check_all("rst_prio", '0, 1'b0, '0, '0, 1'b0);
        check_output("rst_prio.retired_cnt", retired_cnt, '0);
        rst    = 1'b0;
        freeze = 1'b0;
        flush  = 1'b0;

        // Retire count: 4 issues, freeze, 3 issues, bubble, freeze, 3 issues, drain
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 4'(i), 32'(i), '0, 32'(i));
            tick();
        end
        freeze = 1'b1;
        tick();
        freeze = 1'b0;
        for (int i = 4; i < 7; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 4'(i), 32'(i), '0, 32'(i));
            tick();
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        check_output("cnt.mid", retired_cnt, cnt_exp(7));
        freeze = 1'b1;
        tick();
        freeze = 1'b0;
        for (int i = 7; i < 10; i++) begin
            apply_stimulus(1'b1, 1'b1, 1'b0, 4'(i), 32'(i), '0, 32'(i));
            tick();
        end
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        check_output("cnt.ten", retired_cnt, cnt_exp(10));

        // Wrap from all-ones to zero
        apply_stimulus(1'b1, 1'b1, 1'b0, 4'd1, 32'h1, '0, 32'h200);
        tick();
`ifdef WB_RETIRE_CNT_EN
        force dut.retire_cnt_q = '1;
        #1;
        release dut.retire_cnt_q;
        #1;
        check_output("cnt.preload", retired_cnt, {RETIRE_CNT_LEN{1'b1}});
`endif
        apply_stimulus(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
        tick();
        check_output("cnt.wrap", retired_cnt, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The parameter list SHALL be: REG_ADDR_LEN, default 4, width of the destination-register index.
REQ-002 The parameter list SHALL be: RETIRE_CNT_LEN, default 32, width of the retired-instruction counter.
REQ-003 Port clk SHALL be input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 Port rst SHALL be input, 1 bit; reset is synchronous and active-high.
REQ-005 Port freeze SHALL be input, 1 bit, stall: hold all pipeline state.
REQ-006 Port flush SHALL be input, 1 bit, load a bubble instead of the incoming instruction.
REQ-007 Port valid_in SHALL be input, 1 bit, incoming instruction from the memory stage is real.
REQ-008 Port pc_in SHALL be input, `ADDRESS_LEN bits, PC of the incoming instruction.
REQ-009 Ports WB_EN_in and MEM_R_EN_in SHALL be inputs, 1 bit each: register-write request and load indicator.
REQ-010 Port Dest_in SHALL be input, REG_ADDR_LEN bits, destination register.
REQ-011 Port ALU_Res_in SHALL be input, `WORD_LEN bits, ALU result / memory address.
REQ-012 Port Mem_Data_in SHALL be input, `WORD_LEN bits, memory stage read data.
REQ-013 Port pc SHALL be output, `ADDRESS_LEN bits, registered PC.
REQ-014 Port WB_EN SHALL be output, 1 bit, register-file write enable.
REQ-015 Port Dest SHALL be output, REG_ADDR_LEN bits, register-file write index.
REQ-016 Port WB_Value SHALL be output, `WORD_LEN bits, register-file write data.
REQ-017 Port wb_valid SHALL be output, 1 bit, registered instruction is real.
REQ-018 Port retired_cnt SHALL be output, RETIRE_CNT_LEN bits, count of retired instructions.

Function
REQ-019 On a rising edge with rst=0, flush=1, the stage register SHALL load a bubble: valid=0, WB_EN=0, MEM_R_EN=0, Dest=0, data/PC=0; flush overrides freeze.
REQ-020 On a rising edge with rst=0, flush=0, freeze=1, every stage register SHALL hold its value.
REQ-021 On a rising edge with rst=0, flush=0, freeze=0, the stage register SHALL capture all *_in inputs; latency from input to outputs is exactly one cycle.
REQ-022 WB_EN SHALL equal registered WB_EN AND registered valid; a bubble never writes.
REQ-023 WB_Value SHALL be combinational from registered state: Mem_Data when registered MEM_R_EN=1, else ALU_Res.
REQ-024 pc, Dest and wb_valid SHALL be driven directly from the registered values.
REQ-025 While freeze=1, WB_EN SHALL remain asserted if set; the register file sees a repeated identical write, which is harmless.
REQ-026 The retired-instruction counter SHALL be updated per the CONFIG macro (REQ-029/REQ-030).

Reset
REQ-027 On a rising edge with rst=1, all stage registers SHALL clear to 0; rst has priority over flush and freeze.
REQ-028 During and after reset, until new capture: pc=0, WB_EN=0, Dest=0, WB_Value=0, wb_valid=0, retired_cnt=0.

Configuration
REQ-029 With macro WB_RETIRE_CNT_EN defined, retired_cnt SHALL increment by 1 on each rising edge where rst=0, registered valid=1 and freeze=0, wrapping from all-ones to 0; flush does not block the increment of the instruction leaving.
REQ-030 With WB_RETIRE_CNT_EN undefined, no counter register SHALL be built and retired_cnt SHALL be tied to 0; all other behaviour is identical.

Verification
REQ-031 The bench SHALL cover: rst=1 one cycle, inputs nonzero -> all outputs 0 next cycle.
REQ-032 The bench SHALL cover: valid_in=1, WB_EN_in=1, MEM_R_EN_in=1, Dest_in=3, Mem_Data_in=0xDEADBEEF, ALU_Res_in=0x40 -> next cycle WB_EN=1, Dest=3, WB_Value=0xDEADBEEF; repeat with MEM_R_EN_in=0 -> WB_Value=0x40.
REQ-033 The bench SHALL cover: instruction Dest=5 latched, then freeze=1 for 3 cycles with new inputs Dest_in=7 -> Dest stays 5, WB_EN stays 1; freeze=0 -> Dest=7 next cycle.
REQ-034 The bench SHALL cover: flush=1 and freeze=1 together with valid_in=1, WB_EN_in=1 -> next cycle wb_valid=0, WB_EN=0.
REQ-035 The bench SHALL cover, with WB_RETIRE_CNT_EN: 10 valid instructions with 2 frozen cycles and 1 bubble interleaved -> retired_cnt=10; counter preloaded 0xFFFFFFFF by forcing, one retire -> 0. Without the macro -> retired_cnt=0 throughout.
